// File: rtl/io_bus_pkg.sv
// Shared types and helpers for the IO system bus initiator.
package io_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRdWait,
    StRsp
  } io_init_state_t;

  localparam int unsigned IO_LANE_LSB      = 2;
  localparam int unsigned IO_ADDRESS_WIDTH = 32;
  localparam int unsigned IO_DATA_WIDTH    = 32;

  typedef struct packed {
    logic                        write;
    logic [IO_ADDRESS_WIDTH-1:0] address;
    logic [IO_DATA_WIDTH-1:0]    data;
  } io_cmd_t;

  // Top bit of the lane index inside a byte address for a bus of the given width.
  function automatic int unsigned io_lane_msb(input int unsigned bus_width);
    return $clog2(bus_width / 8) - 1;
  endfunction

endpackage

// File: rtl/io_timeout_counter.sv
// Wait-state counter; o_expired flags the last permitted wait cycle.
module io_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Expiry is flagged one count early so the FSM leaves exactly TIMEOUT_CYCLES after entry.
  assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/io_bus_initiator.sv
// Single-outstanding IO bus initiator: core valid/ready port to n2m/m2n device signals.
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = IO_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH     = IO_DATA_WIDTH,
  parameter int unsigned BUS_WIDTH      = 512,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_error,
  output logic [ADDRESS_WIDTH-1:0] n2m_request_address,
  output logic [BUS_WIDTH-1:0]     n2m_request_data,
  output logic                     n2m_request_read,
  output logic                     n2m_request_write,
  output logic                     mc_avail_o,
  input  logic                     m2n_request_available,
  input  logic                     m2n_response_valid,
  input  logic [ADDRESS_WIDTH-1:0] m2n_response_address,
  input  logic [BUS_WIDTH-1:0]     m2n_response_data
);

  localparam int unsigned NUM_LANES = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned LANE_MSB  = io_lane_msb(BUS_WIDTH);

  io_init_state_t               r_state, w_state_next;
  io_cmd_t                      r_cmd;
  logic [DATA_WIDTH-1:0]        r_rsp_data;
  logic                         r_rsp_error;
  logic                         w_expired, w_cnt_clear, w_cnt_enable, w_timeout;
  logic                         w_run, w_accept;
  logic [LANE_MSB-IO_LANE_LSB:0] w_lane;
  logic [DATA_WIDTH-1:0]        w_lane_data;
  logic                         w_unused_rsp_addr;

  assign w_unused_rsp_addr = ^m2n_response_address;

  assign w_accept    = (r_state == StIdle) && req_valid;
  assign w_lane      = r_cmd.address[LANE_MSB:IO_LANE_LSB];
  assign w_lane_data = m2n_response_data[int'(w_lane) * DATA_WIDTH +: DATA_WIDTH];

  io_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_enable),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_enable = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_valid) w_state_next = StIssue;
      end
      StIssue: begin
        if (!r_cmd.write) begin
          w_state_next = StRdWait;
        end else begin
          w_cnt_enable = 1'b1;
          if (m2n_request_available) begin
            w_state_next = StRsp;
          end else if (w_expired) begin
            w_state_next = StRsp;
            w_timeout    = 1'b1;
          end
        end
      end
      StRdWait: begin
        w_cnt_enable = 1'b1;
        if (m2n_response_valid) begin
          w_state_next = StRsp;
        end else if (w_expired) begin
          w_state_next = StRsp;
          w_timeout    = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // Any state change restarts the wait count for the state being entered.
    w_cnt_clear = (w_state_next != r_state);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cmd       <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cmd       <= '{write:   req_write,
                         address: IO_ADDRESS_WIDTH'(req_address),
                         data:    IO_DATA_WIDTH'(req_data)};
        r_rsp_data  <= '0;
        r_rsp_error <= 1'b0;
      end
      if (r_state == StRdWait && m2n_response_valid) begin
        r_rsp_data <= w_lane_data;
      end
      if (w_timeout) begin
        r_rsp_error <= 1'b1;
      end
    end
  end

  // Every output is forced low while reset is held, regardless of state.
  assign w_run               = !reset;
  assign req_ready           = w_run && (r_state == StIdle);
  assign rsp_valid           = w_run && (r_state == StRsp);
  assign rsp_data            = rsp_valid ? r_rsp_data : '0;
  assign rsp_error           = rsp_valid && r_rsp_error;
  assign n2m_request_address = w_run ? ADDRESS_WIDTH'(r_cmd.address) : '0;
  assign n2m_request_data    = w_run ? {NUM_LANES{DATA_WIDTH'(r_cmd.data)}} : '0;
  assign n2m_request_read    = w_run && (r_state == StIssue) && !r_cmd.write;
  assign n2m_request_write   = w_run && (r_state == StIssue) && r_cmd.write &&
                               m2n_request_available;
  assign mc_avail_o          = w_run && (r_state == StRdWait);

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed bench: a main initiator with a lane-mapped test device, plus a short-timeout instance.
module tb_io_bus_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset       = 1'b1;
  logic         req_valid   = 1'b0;
  logic         req_write   = 1'b0;
  logic [31:0]  req_address = '0;
  logic [31:0]  req_data    = '0;
  logic         rsp_ready   = 1'b0;
  logic         req_ready, rsp_valid, rsp_error;
  logic [31:0]  rsp_data, n2m_request_address, m2n_response_address;
  logic [511:0] n2m_request_data, m2n_response_data;
  logic         n2m_request_read, n2m_request_write, mc_avail_o;
  logic         m2n_request_available, m2n_response_valid;

  logic         to_req_valid = 1'b0;
  logic         to_rsp_ready = 1'b0;
  logic         to_req_ready, to_rsp_valid, to_rsp_error;
  logic [31:0]  to_rsp_data, to_n2m_request_address;
  logic [511:0] to_n2m_request_data;
  logic         to_n2m_request_read, to_n2m_request_write, to_mc_avail_o;

  logic         dev_busy  = 1'b0;
  logic         dev_dead  = 1'b0;
  logic         force_rsp = 1'b0;
  logic [31:0]  dev_reg [16];
  logic [31:0]  dev_cnt;
  logic         dev_pend, dev_rsp;
  logic [511:0] dev_bus;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  io_bus_initiator dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_address          (req_address),
    .req_data             (req_data),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_data             (rsp_data),
    .rsp_error            (rsp_error),
    .n2m_request_address  (n2m_request_address),
    .n2m_request_data     (n2m_request_data),
    .n2m_request_read     (n2m_request_read),
    .n2m_request_write    (n2m_request_write),
    .mc_avail_o           (mc_avail_o),
    .m2n_request_available(m2n_request_available),
    .m2n_response_valid   (m2n_response_valid),
    .m2n_response_address (m2n_response_address),
    .m2n_response_data    (m2n_response_data)
  );

  io_bus_initiator #(
    .TIMEOUT_CYCLES(8)
  ) dut_to (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (to_req_valid),
    .req_ready            (to_req_ready),
    .req_write            (req_write),
    .req_address          (req_address),
    .req_data             (req_data),
    .rsp_valid            (to_rsp_valid),
    .rsp_ready            (to_rsp_ready),
    .rsp_data             (to_rsp_data),
    .rsp_error            (to_rsp_error),
    .n2m_request_address  (to_n2m_request_address),
    .n2m_request_data     (to_n2m_request_data),
    .n2m_request_read     (to_n2m_request_read),
    .n2m_request_write    (to_n2m_request_write),
    .mc_avail_o           (to_mc_avail_o),
    .m2n_request_available(1'b0),
    .m2n_response_valid   (1'b0),
    .m2n_response_address (32'h0),
    .m2n_response_data    (512'h0)
  );

  // Test register device: lane 3 is a free-running counter, other lanes are writable.
  assign m2n_request_available = !dev_busy;
  assign m2n_response_valid    = dev_rsp | force_rsp;
  assign m2n_response_address  = n2m_request_address;

  always_comb begin
    dev_bus = '0;
    for (int i = 0; i < 16; i++) begin
      dev_bus[i*32 +: 32] = (i == 3) ? dev_cnt : dev_reg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) dev_reg[i] <= 32'hA000_0000 + 32'(i);
      dev_cnt           <= '0;
      dev_pend          <= 1'b0;
      dev_rsp           <= 1'b0;
      m2n_response_data <= '0;
    end else begin
      dev_cnt <= dev_cnt + 1;
      dev_rsp <= 1'b0;
      if (n2m_request_write) begin
        dev_reg[n2m_request_address[5:2]] <= n2m_request_data[n2m_request_address[5:2]*32 +: 32];
      end
      if (n2m_request_read) begin
        dev_pend <= 1'b1;
      end else if (dev_pend && mc_avail_o && !dev_dead) begin
        dev_rsp           <= 1'b1;
        dev_pend          <= 1'b0;
        m2n_response_data <= dev_bus;
      end
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Called in an idle cycle; returns in the idle cycle after the response handshake.
  task automatic do_read(input string tag, input logic [31:0] a, output logic [31:0] d);
    int n;
    n = 0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_address = a;
    nxt();
    req_valid = 1'b0;
    while (!rsp_valid && n < 20) begin
      nxt();
      n++;
    end
    chk({tag, "_wait"}, rsp_valid, 1'b1);
    d         = rsp_data;
    rsp_ready = 1'b1;
    nxt();
    rsp_ready = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] d, c1, c2;
    int n_wr, n_rv, n_bad;

    // Reset
    nxt();
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_n2m_data", n2m_request_data, '0);
    nxt();
    reset = 1'b0;
    nxt();
    #1;
    chk("idle_req_ready", req_ready, 1'b1);

    // Write 0xDEADBEEF to 0x4, device available
    nxt();
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h4; req_data = 32'hDEADBEEF;
    #1;
    chk("wr1_accept", req_ready, 1'b1);
    nxt();
    req_valid = 1'b0;
    #1;
    chk("wr1_strobe", n2m_request_write, 1'b1);
    chk("wr1_addr", n2m_request_address, 32'h4);
    chk("wr1_lanes", n2m_request_data, {16{32'hDEADBEEF}});
    chk("wr1_busy_ready", req_ready, 1'b0);
    nxt();
    rsp_ready = 1'b1;
    #1;
    chk("wr1_rsp_valid", rsp_valid, 1'b1);
    chk("wr1_rsp_error", rsp_error, 1'b0);
    chk("wr1_rsp_data", rsp_data, 32'h0);
    chk("wr1_strobe_once", n2m_request_write, 1'b0);
    nxt();
    rsp_ready = 1'b0;
    #1;
    chk("wr1_ready_again", req_ready, 1'b1);

    // Write 0x11 to 0x0, then 0x22 to 0x8 with the device busy 31 cycles
    req_valid = 1'b1; req_address = 32'h0; req_data = 32'h11;
    nxt();
    req_valid = 1'b0;
    #1;
    chk("wr2_strobe", n2m_request_write, 1'b1);
    nxt();
    rsp_ready = 1'b1;
    #1;
    chk("wr2_rsp_valid", rsp_valid, 1'b1);
    chk("wr2_rsp_error", rsp_error, 1'b0);
    nxt();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_address = 32'h8; req_data = 32'h22; dev_busy = 1'b1;
    #1;
    chk("wr3_accept", req_ready, 1'b1);
    nxt();
    req_valid = 1'b0;
    #1;
    n_wr = 0; n_rv = 0;
    for (int i = 0; i < 31; i++) begin
      n_wr += int'(n2m_request_write);
      n_rv += int'(rsp_valid);
      nxt();
    end
    chk("wr3_no_strobe_busy", n_wr, 0);
    chk("wr3_no_rsp_busy", n_rv, 0);
    dev_busy = 1'b0;
    #1;
    chk("wr3_strobe", n2m_request_write, 1'b1);
    chk("wr3_addr", n2m_request_address, 32'h8);
    nxt();
    rsp_ready = 1'b1;
    #1;
    chk("wr3_rsp_valid", rsp_valid, 1'b1);
    chk("wr3_rsp_error", rsp_error, 1'b0);
    nxt();
    rsp_ready = 1'b0;

    // Read 0x4: strobe at T+1, response at T+4, then 5 held cycles
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h4;
    #1;
    chk("rd1_accept", req_ready, 1'b1);
    nxt();
    req_valid = 1'b0;
    #1;
    chk("rd1_strobe", n2m_request_read, 1'b1);
    chk("rd1_addr", n2m_request_address, 32'h4);
    chk("rd1_avail_t1", mc_avail_o, 1'b0);
    nxt();
    #1;
    chk("rd1_strobe_once", n2m_request_read, 1'b0);
    chk("rd1_avail_t2", mc_avail_o, 1'b1);
    nxt();
    #1;
    chk("rd1_no_rsp_t3", rsp_valid, 1'b0);
    chk("rd1_no_strobe_t3", n2m_request_read, 1'b0);
    nxt();
    #1;
    chk("rd1_rsp_t4", rsp_valid, 1'b1);
    chk("rd1_data", rsp_data, 32'hDEADBEEF);
    chk("rd1_error", rsp_error, 1'b0);
    chk("rd1_avail_t4", mc_avail_o, 1'b0);
    n_bad = 0;
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF || req_ready !== 1'b0) n_bad++;
    end
    chk("rd1_hold_stable", n_bad, 0);
    rsp_ready = 1'b1;
    nxt();
    rsp_ready = 1'b0;
    #1;
    chk("rd1_ready_after", req_ready, 1'b1);

    // Lane extraction
    do_read("rd_lane2", 32'h8, d);
    chk("rd_lane2", d, 32'h22);
    do_read("rd_cnt1", 32'hC, c1);
    do_read("rd_cnt2", 32'hC, c2);
    chk("rd_cnt_increases", c2 > c1, 1'b1);
    chk("rd_cnt_lane3", (c1 > 32'h22) && (c1 < 32'h1000), 1'b1);

    // Timeout instance: read with a device that never replies
    to_req_valid = 1'b1; req_write = 1'b0; req_address = 32'h10;
    #1;
    chk("to_rd_accept", to_req_ready, 1'b1);
    nxt();
    to_req_valid = 1'b0;
    #1;
    chk("to_rd_strobe", to_n2m_request_read, 1'b1);
    chk("to_rd_addr", to_n2m_request_address, 32'h10);
    nxt();
    #1;
    chk("to_rd_avail", to_mc_avail_o, 1'b1);
    n_rv = 0;
    for (int i = 0; i < 7; i++) begin
      nxt();
      n_rv += int'(to_rsp_valid);
    end
    chk("to_rd_no_early_rsp", n_rv, 0);
    nxt();
    #1;
    chk("to_rd_rsp_at_8", to_rsp_valid, 1'b1);
    chk("to_rd_error", to_rsp_error, 1'b1);
    chk("to_rd_data", to_rsp_data, 32'h0);
    chk("to_rd_avail_off", to_mc_avail_o, 1'b0);
    to_rsp_ready = 1'b1;
    nxt();
    to_rsp_ready = 1'b0;
    #1;
    chk("to_rd_ready_again", to_req_ready, 1'b1);

    // Timeout instance: write with the device never available
    to_req_valid = 1'b1; req_write = 1'b1; req_data = 32'h5555AAAA;
    nxt();
    to_req_valid = 1'b0;
    #1;
    chk("to_wr_lanes", to_n2m_request_data, {16{32'h5555AAAA}});
    n_wr = 0; n_rv = 0;
    for (int i = 0; i < 8; i++) begin
      n_wr += int'(to_n2m_request_write);
      n_rv += int'(to_rsp_valid);
      nxt();
    end
    chk("to_wr_no_strobe", n_wr, 0);
    chk("to_wr_no_early_rsp", n_rv, 0);
    chk("to_wr_rsp", to_rsp_valid, 1'b1);
    chk("to_wr_error", to_rsp_error, 1'b1);
    chk("to_wr_data", to_rsp_data, 32'h0);
    to_rsp_ready = 1'b1;
    nxt();
    to_rsp_ready = 1'b0;
    #1;
    chk("to_wr_no_late_strobe", to_n2m_request_write, 1'b0);

    // Reset during RD_WAIT, then a late reply
    dev_dead = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h4;
    #1;
    chk("rr_accept", req_ready, 1'b1);
    nxt();
    req_valid = 1'b0;
    nxt();
    #1;
    chk("rr_in_rdwait", mc_avail_o, 1'b1);
    reset = 1'b1;
    nxt();
    #1;
    chk("rr_avail_zero", mc_avail_o, 1'b0);
    chk("rr_req_ready_zero", req_ready, 1'b0);
    chk("rr_addr_zero", n2m_request_address, 32'h0);
    chk("rr_data_zero", n2m_request_data, '0);
    chk("rr_rsp_zero", rsp_valid, 1'b0);
    reset     = 1'b0;
    force_rsp = 1'b1;
    nxt();
    #1;
    chk("rr_late_no_rsp", rsp_valid, 1'b0);
    chk("rr_idle", req_ready, 1'b1);
    nxt();
    force_rsp = 1'b0;
    #1;
    chk("rr_still_no_rsp", rsp_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/io_bus_initiator.md
# io_bus_initiator

Single-outstanding initiator for the memory-mapped IO system bus. Accepts one-word read/write commands from a core-side valid/ready port and drives the `n2m_request_*` signals toward an IO device. Collects the device's `m2n_*` reply, extracts the addressed 32-bit lane, and returns a response through a one-entry buffer. Sits between a core's IO port and an IO device such as the test register device, with a timeout so a dead device cannot hang the core.

## Interface
- `ADDRESS_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, core word width
- `BUS_WIDTH`, 512, system bus data width; must be a multiple of `DATA_WIDTH`
- `TIMEOUT_CYCLES`, 255, maximum cycles spent in a wait state; range 1..65535
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  command valid
- `req_ready`  out  1  command accepted when high together with `req_valid`
- `req_write`  in  1  1 = write, 0 = read
- `req_address`  in  ADDRESS_WIDTH  byte address
- `req_data`  in  DATA_WIDTH  write data
- `rsp_valid`  out  1  response held valid until `rsp_ready`
- `rsp_ready`  in  1  core consumes the response
- `rsp_data`  out  DATA_WIDTH  read data; 0 for writes and errors
- `rsp_error`  out  1  transaction timed out
- `n2m_request_address`  out  ADDRESS_WIDTH  held for the whole transaction
- `n2m_request_data`  out  BUS_WIDTH  `req_data` replicated across every lane
- `n2m_request_read`  out  1  one-cycle read strobe
- `n2m_request_write`  out  1  one-cycle write strobe
- `mc_avail_o`  out  1  initiator can accept a read reply
- `m2n_request_available`  in  1  device can accept a write
- `m2n_response_valid`  in  1  read reply valid
- `m2n_response_address`  in  ADDRESS_WIDTH  echoed address; ignored
- `m2n_response_data`  in  BUS_WIDTH  reply data

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On handshake, capture the command and go to ISSUE.
  - ISSUE, read: assert `n2m_request_read` for one cycle, then go to RD_WAIT.
  - ISSUE, write: assert `n2m_request_write` only in a cycle where `m2n_request_available`=1, then go to RSP. While the device is unavailable, stay in ISSUE with the timeout running.
  - RD_WAIT: `mc_avail_o`=1. On `m2n_response_valid`, capture lane `address[5:2]` (generally `log2(BUS_WIDTH/8)-1 : 2`) of `m2n_response_data` and go to RSP.
  - RSP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Timeout: counter cleared on entry to ISSUE or RD_WAIT and incremented each cycle spent waiting. When it reaches `TIMEOUT_CYCLES`, go to RSP with `rsp_error`=1 and `rsp_data`=0. No strobe is issued after expiry.
- Lane extraction uses address bits only; address bits [1:0] are ignored.
- Write data is replicated to all `BUS_WIDTH/DATA_WIDTH` lanes so that any lane-mapped register sees it.
- `m2n_response_valid` outside RD_WAIT is ignored.
- Reset values:
  - All outputs 0, including `req_ready` while `reset` is high.
  - FSM goes to IDLE and the captured command is discarded.
- Reset mid-transaction: any outstanding reply is dropped and no response is generated.

## Timing
- Accept in cycle T; ISSUE in T+1.
- Write:
  - Strobe at T+1 if the device is available.
  - `rsp_valid` at T+2.
  - Each unavailable cycle adds 1.
- Read:
  - Strobe at T+1; RD_WAIT from T+2 with `mc_avail_o`=1.
  - With a device replying one cycle after `mc_avail_o`, `m2n_response_valid` arrives at T+3 and `rsp_valid` rises at T+4.
- Response buffer:
  - `rsp_valid` stays high with stable data until `rsp_ready`.
  - `req_ready` rises the cycle after the RSP handshake; throughput is one transaction per ≥3 cycles.
- Outputs are decoded from state plus registered command; no combinational path from `req_*` to `n2m_*`.

## Structure
- Package `io_bus_pkg`:
  - `io_init_state_t` enum (IDLE, ISSUE, RD_WAIT, RSP)
  - `IO_LANE_LSB`=2 and a lane-index function of `BUS_WIDTH`
  - `io_cmd_t` struct (write, address, data)
- Sub-module `io_timeout_counter`: clear, enable, expired output, width `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Write `0xDEADBEEF` to `0x4`, device available → `n2m_request_write` pulse at T+1, all 16 lanes `0xDEADBEEF`, `rsp_valid` at T+2 with `rsp_error`=0.
- Write `0x11` to `0x0`, immediately followed by a write of `0x22` to `0x8` while the device is busy for 31 cycles → second strobe only after `m2n_request_available`=1; both responses have `rsp_error`=0.
- Read `0x4` after the first test → `rsp_data`=`0xDEADBEEF` at T+4; `n2m_request_read` high exactly one cycle.
- Read `0xC` twice → second `rsp_data` is greater than the first (device free-running counter); lane 3 is extracted.
- `TIMEOUT_CYCLES`=8 with a device that never responds → `rsp_valid` exactly 8 cycles after RD_WAIT entry, `rsp_error`=1, `rsp_data`=0. Same result for a write with `m2n_request_available` held at 0.
- Hold `rsp_ready`=0 for 5 cycles, then pulse it → data stable and `req_ready`=0 throughout. Assert `reset` during RD_WAIT → all outputs 0 next cycle, and a late `m2n_response_valid` produces no response.
